controle: RTL

Multicycle control unit for the 8-bit teaching processor. It sits directly upstream of the `ula` ALU: it sequences fetch, decode, execute, memory and write-back, and drives `ALUctl` with the decoded opcode. It consumes the ALU `Zero` flag to resolve `beq`/`bne`. It also handshakes with instruction/data memory and produces the datapath enables for the PC, IR, register file and memory.

---
 rtl/controle_pkg.sv | 27 ++
 rtl/contador_instr.sv | 18 +
 rtl/controle.sv | 126 ++++++++++++
 3 files changed

// File: rtl/controle_pkg.sv
// rtl/controle_pkg.sv - shared opcode, state and ALU-idle constants for controle
package controle_pkg;

    typedef enum logic [2:0] {
        BUSCA   = 3'd0,
        DECOD   = 3'd1,
        EXEC    = 3'd2,
        MEM     = 3'd3,
        ESCREVE = 3'd4,
        PARADO  = 3'd5
    } state_t;

    localparam logic [3:0] OP_HLF   = 4'd1;
    localparam logic [3:0] OP_LFH   = 4'd2;
    localparam logic [3:0] OP_BNE   = 4'd3;
    localparam logic [3:0] OP_LW    = 4'd4;
    localparam logic [3:0] OP_SW    = 4'd5;
    localparam logic [3:0] OP_BEQ   = 4'd6;
    localparam logic [3:0] OP_CNT   = 4'd7;
    localparam logic [3:0] OP_SET   = 4'd8;
    localparam logic [3:0] ALU_IDLE = 4'd0;

    function automatic logic is_legal(input logic [3:0] opc);
        return (opc >= OP_HLF) && (opc <= OP_SET);
    endfunction

endpackage

// File: rtl/contador_instr.sv
// rtl/contador_instr.sv - wrapping counter with synchronous clear and enable
module contador_instr #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (clear)
            count <= '0;
        else if (enable)
            count <= count + W'(1);
    end

endmodule

// File: rtl/controle.sv
// rtl/controle.sv - multicycle control unit: fetch, decode, execute, memory, write-back
module controle
    import controle_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       Opcode,
    input  logic             Zero,
    input  logic             MemReady,
    output logic [3:0]       ALUctl,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             MemToReg,
    output logic             Halt,
    output logic [2:0]       State,
    output logic [CNT_W-1:0] InstrCount
);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] op;
    logic       retire;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= BUSCA;
            op      <= ALU_IDLE;
        end else begin
            state_q <= state_d;
            if (state_q == DECOD)
                op <= Opcode;
        end
    end

    always_comb begin
        state_d  = state_q;
        ALUctl   = ALU_IDLE;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        MemToReg = 1'b0;
        Halt     = 1'b0;
        retire   = 1'b0;

        case (state_q)
            BUSCA: begin
                MemRead = 1'b1;
                if (MemReady) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = DECOD;
                end
            end

            DECOD: begin
                state_d = is_legal(Opcode) ? EXEC : PARADO;
            end

            EXEC: begin
                ALUctl = op;
                case (op)
                    OP_HLF, OP_LFH, OP_CNT, OP_SET: state_d = ESCREVE;
                    // ula reports "taken" as Zero=1 for both beq and bne
                    OP_BEQ, OP_BNE: begin
                        PCWrite = Zero;
                        PCSrc   = Zero;
                        retire  = 1'b1;
                        state_d = BUSCA;
                    end
                    OP_LW, OP_SW:                   state_d = MEM;
                    default:                        state_d = BUSCA;
                endcase
            end

            MEM: begin
                ALUctl   = op;
                MemRead  = (op == OP_LW);
                MemWrite = (op == OP_SW);
                if (MemReady) begin
                    if (op == OP_LW) begin
                        state_d = ESCREVE;
                    end else begin
                        retire  = 1'b1;
                        state_d = BUSCA;
                    end
                end
            end

            ESCREVE: begin
                ALUctl   = op;
                RegWrite = 1'b1;
                MemToReg = (op == OP_LW);
                retire   = 1'b1;
                state_d  = BUSCA;
            end

            PARADO: begin
                Halt    = 1'b1;
                state_d = PARADO;
            end

            default: state_d = BUSCA;
        endcase
    end

    assign State = state_q;

    contador_instr #(
        .W (CNT_W)
    ) u_contador (
        .clock  (clock),
        .clear  (reset),
        .enable (retire),
        .count  (InstrCount)
    );

endmodule
